hs_reg_pipeline: RTL

- Parametrised elastic register pipeline: DEPTH valid/ready-handshaked register stages of DATA_WIDTH bits each.
- Successor to the plain single-bit reset register. It generalises width and depth and adds flow control, bubble collapsing, synchronous flush, a configurable reset value and an occupancy count.
- Used to cut long timing paths on handshaked streams without losing throughput.

---
 rtl/hs_reg_pipeline.sv | 80 ++++++++
 1 files changed

// File: rtl/hs_reg_pipeline.sv
// Elastic valid/ready register pipeline: DEPTH stages of DATA_WIDTH bits, with flush and occupancy.
// Latency is DEPTH cycles. Empty stages collapse toward the output, so a stall never costs capacity.
// Backpressure: when the pipeline is full, dout_rd passes straight through to din_rd, so a simultaneous read loses no cycle.
module hs_reg_pipeline #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        din_data,
  input  logic                         din_vld,
  output logic                         din_rd,
  output logic [DATA_WIDTH-1:0]        dout_data,
  output logic                         dout_vld,
  input  logic                         dout_rd,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]      vld;
  logic [DEPTH-1:0]      vld_nxt;
  logic [DEPTH-1:0]      rd;
  logic [DEPTH-1:0]      mv;
  logic [DATA_WIDTH-1:0] data [DEPTH];
  logic [OCC_W-1:0]      occ_nxt;

  // A stage is ready when any stage downstream of it is empty or the consumer is taking a word;
  // the running OR avoids a self-referencing vector.
  always_comb begin
    logic r;
    r  = dout_rd;
    rd = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      rd[i] = r;
      r     = r | !vld[i];
    end
  end

  assign mv     = ~vld | rd;
  assign din_rd = mv[0] & !flush;

  always_comb begin
    vld_nxt = vld;
    if (mv[0]) vld_nxt[0] = din_vld;
    for (int i = 1; i < DEPTH; i++) begin
      if (mv[i]) vld_nxt[i] = vld[i-1];
    end
    if (flush) vld_nxt = '0;
  end

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) occ_nxt = occ_nxt + OCC_W'(vld_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld       <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= INIT_VAL;
    end else begin
      vld       <= vld_nxt;
      occupancy <= occ_nxt;
      // Data moves only with a valid word; flush leaves the data registers untouched.
      if (!flush) begin
        if (mv[0] && din_vld) data[0] <= din_data;
        for (int i = 1; i < DEPTH; i++) begin
          if (mv[i] && vld[i-1]) data[i] <= data[i-1];
        end
      end
    end
  end

  assign dout_data = data[DEPTH-1];
  assign dout_vld  = vld[DEPTH-1];

endmodule
